// File: rtl/leading_1_in_mantissa_pkg.sv
// Shared constants and the behavioural reference encoder for the
// leading-one detector used in the FP adder normalisation path.
package leading_1_pkg;

   // Architecture selector strings accepted by the IMPLEMENTATION parameter.
   localparam string IMPL_NAIVE = "NAIVE";
   localparam string IMPL_FPGA  = "FPGA";

   typedef enum logic [0:0] {
      IMPL_SEL_NAIVE = 1'b0,
      IMPL_SEL_FPGA  = 1'b1
   } impl_sel_e;

   // Linear priority chain: later (higher) set bits overwrite earlier ones,
   // so an unknown bit below the leading one can never reach the result.
   function automatic int msb_pos_ref(logic [63:0] v, int width);
      int pos;
      pos = 0;
      for (int i = 0; i < 64; i++) begin
         if ((i < width) && (v[i] == 1'b1)) begin
            pos = i;
         end
      end
      return pos;
   endfunction

endpackage

// File: rtl/leading_1_in_mantissa_if.sv
// Request/response bundle of the leading-one detector.
interface leading_1_in_mantissa_if #(
   parameter int WIDTH = 8
);
   localparam int WIDTH_LOG = $clog2(WIDTH);

   logic                 in_valid;
   logic [WIDTH-1:0]     Sum_mag;
   logic                 out_valid;
   logic [WIDTH_LOG-1:0] msb_pos;
   logic                 zero;

   modport master (
      output in_valid,
      output Sum_mag,
      input  out_valid,
      input  msb_pos,
      input  zero
   );

   modport slave (
      input  in_valid,
      input  Sum_mag,
      output out_valid,
      output msb_pos,
      output zero
   );
endinterface

// File: rtl/leading_1_in_mantissa_tree_node.sv
// One pairwise merge step of the balanced leading-one tree. The high child
// wins whenever it holds a one, so the low child's position is only looked
// at when everything above it is zero.
module leading_1_tree_node #(
   parameter int POS_W = 1
) (
   input  logic             valid_hi,
   input  logic             valid_lo,
   input  logic [POS_W-1:0] pos_hi,
   input  logic [POS_W-1:0] pos_lo,
   output logic             valid,
   output logic [POS_W:0]   pos
);

   // Merge two half-results; the select never depends on the low half.
   always_comb begin
      valid = valid_hi | valid_lo;
      pos   = valid_hi ? {1'b1, pos_hi} : {1'b0, pos_lo};
   end

endmodule

// File: rtl/leading_1_in_mantissa.sv
// Leading-one position of an unsigned mantissa magnitude with a single
// registered output stage (1-cycle latency, one result per cycle).
module leading_1_in_mantissa
   import leading_1_pkg::*;
#(
   parameter int    WIDTH          = 8,
   parameter string IMPLEMENTATION = "FPGA"
) (
   input  logic                   clk,
   input  logic                   rst,
   leading_1_in_mantissa_if.slave bus
);

   localparam int WIDTH_LOG = $clog2(WIDTH);

   logic [WIDTH_LOG-1:0] pos_s;
   logic                 zero_s;
   logic [WIDTH_LOG-1:0] msb_pos_r;
   logic                 zero_r;
   logic                 out_valid_r;

   if ((WIDTH < 2) || (WIDTH > 64)) begin : gen_bad_width
      $fatal(1, "leading_1_in_mantissa: WIDTH=%0d outside 2..64", WIDTH);
   end

   if (IMPLEMENTATION == IMPL_NAIVE) begin : gen_naive
      // Linear priority chain through the shared reference encoder.
      always_comb begin
         pos_s  = WIDTH_LOG'(msb_pos_ref(64'(bus.Sum_mag), WIDTH));
         zero_s = ~|bus.Sum_mag;
      end
   end else if (IMPLEMENTATION == IMPL_FPGA) begin : gen_fpga
      localparam int PAD = 2 ** WIDTH_LOG;

      // Zero padding up to a power of two keeps every tree level full.
      logic [PAD-1:0] sum_pad_s;
      assign sum_pad_s = PAD'(bus.Sum_mag);

      for (genvar l = 1; l <= WIDTH_LOG; l++) begin : gen_lvl
         localparam int NODES = PAD >> l;
         logic         valid_v [NODES];
         logic [l-1:0] pos_v   [NODES];

         for (genvar n = 0; n < NODES; n++) begin : gen_node
            if (l == 1) begin : gen_leaf
               // A bit pair: position is simply the upper bit.
               assign valid_v[n] = sum_pad_s[2*n+1] | sum_pad_s[2*n];
               assign pos_v[n]   = sum_pad_s[2*n+1];
            end else begin : gen_merge
               leading_1_tree_node #(
                  .POS_W (l - 1)
               ) u_node (
                  .valid_hi (gen_lvl[l-1].valid_v[2*n+1]),
                  .valid_lo (gen_lvl[l-1].valid_v[2*n]),
                  .pos_hi   (gen_lvl[l-1].pos_v[2*n+1]),
                  .pos_lo   (gen_lvl[l-1].pos_v[2*n]),
                  .valid    (valid_v[n]),
                  .pos      (pos_v[n])
               );
            end
         end
      end

      // Root of the tree: its valid flag is exactly "any bit set".
      assign pos_s  = gen_lvl[WIDTH_LOG].pos_v[0];
      assign zero_s = ~gen_lvl[WIDTH_LOG].valid_v[0];
   end else begin : gen_bad_impl
      $fatal(1, "leading_1_in_mantissa: unknown IMPLEMENTATION '%s'", IMPLEMENTATION);
   end

   // Output stage: capture on a qualified input, hold the result otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         msb_pos_r   <= {WIDTH_LOG{1'b0}};
         zero_r      <= 1'b1;
      end else begin
         out_valid_r <= bus.in_valid;
         if (bus.in_valid) begin
            msb_pos_r <= pos_s;
            zero_r    <= zero_s;
         end
      end
   end

   assign bus.out_valid = out_valid_r;
   assign bus.msb_pos   = msb_pos_r;
   assign bus.zero      = zero_r;

endmodule

// File: tb/tb_leading_1_in_mantissa.sv
// Scoreboard bench: two 8-bit instances (FPGA and NAIVE) driven in lockstep
// plus a 5-bit FPGA instance; monitors pop expected results each cycle.
module tb_leading_1_in_mantissa;

   typedef struct packed {
      logic       ov;
      logic [2:0] pos;
      logic       zero;
   } exp_t;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;
   exp_t qf[$];
   exp_t qn[$];
   exp_t q5[$];
   exp_t ef, en, e5;
   logic [2:0] hold_pos;
   logic       hold_zero;

   leading_1_in_mantissa_if #(.WIDTH(8)) if_f ();
   leading_1_in_mantissa_if #(.WIDTH(8)) if_n ();
   leading_1_in_mantissa_if #(.WIDTH(5)) if_5 ();

   leading_1_in_mantissa #(.WIDTH(8), .IMPLEMENTATION("FPGA"))  dut_fpga  (.clk(clk), .rst(rst), .bus(if_f));
   leading_1_in_mantissa #(.WIDTH(8), .IMPLEMENTATION("NAIVE")) dut_naive (.clk(clk), .rst(rst), .bus(if_n));
   leading_1_in_mantissa #(.WIDTH(5), .IMPLEMENTATION("FPGA"))  dut_w5    (.clk(clk), .rst(rst), .bus(if_5));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   // Independent top-down reference for the exhaustive sweep.
   function automatic int ref_msb8(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) begin
         if (v[i] === 1'b1) return i;
      end
      return 0;
   endfunction

   // Drive both 8-bit instances on the falling edge and queue the expectation.
   task automatic drive(input logic v, input logic [7:0] val, input int ep, input logic ez);
      exp_t e;
      @(negedge clk);
      if_f.in_valid = v;  if_f.Sum_mag = val;
      if_n.in_valid = v;  if_n.Sum_mag = val;
      if (v) begin
         hold_pos  = 3'(ep);
         hold_zero = ez;
      end
      e.ov = v;  e.pos = hold_pos;  e.zero = hold_zero;
      qf.push_back(e);
      qn.push_back(e);
   endtask

   task automatic drive5(input logic [4:0] val, input int ep, input logic ez);
      exp_t e;
      @(negedge clk);
      if_5.in_valid = 1'b1;  if_5.Sum_mag = val;
      e.ov = 1'b1;  e.pos = 3'(ep);  e.zero = ez;
      q5.push_back(e);
   endtask

   // Monitor: one registered result per cycle, checked just after the edge.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         if (qf.size() > 0) begin
            ef = qf.pop_front();
            chk("fpga_out_valid", 8'(if_f.out_valid), 8'(ef.ov));
            chk("fpga_msb_pos",   8'(if_f.msb_pos),   8'(ef.pos));
            chk("fpga_zero",      8'(if_f.zero),      8'(ef.zero));
         end
         if (qn.size() > 0) begin
            en = qn.pop_front();
            chk("naive_out_valid", 8'(if_n.out_valid), 8'(en.ov));
            chk("naive_msb_pos",   8'(if_n.msb_pos),   8'(en.pos));
            chk("naive_zero",      8'(if_n.zero),      8'(en.zero));
         end
         if (q5.size() > 0) begin
            e5 = q5.pop_front();
            chk("w5_out_valid", 8'(if_5.out_valid), 8'(e5.ov));
            chk("w5_msb_pos",   8'(if_5.msb_pos),   8'(e5.pos));
            chk("w5_zero",      8'(if_5.zero),      8'(e5.zero));
         end
      end
   end

   initial begin
      logic [7:0] v8;
      exp_t       e;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      if_f.in_valid = 1'b1;  if_f.Sum_mag = 8'h00;
      if_n.in_valid = 1'b1;  if_n.Sum_mag = 8'h00;
      if_5.in_valid = 1'b1;  if_5.Sum_mag = 5'h00;

      // Reset values while in_valid is asserted.
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_fpga_out_valid", 8'(if_f.out_valid), 8'h00);
      chk("rst_fpga_msb_pos",   8'(if_f.msb_pos),   8'h00);
      chk("rst_fpga_zero",      8'(if_f.zero),      8'h01);
      chk("rst_naive_out_valid", 8'(if_n.out_valid), 8'h00);
      chk("rst_w5_zero",        8'(if_5.zero),      8'h01);

      // Release: first capture of Sum_mag=0 on the next rising edge.
      rst = 1'b0;
      hold_pos = 3'd0;  hold_zero = 1'b1;
      e.ov = 1'b1;  e.pos = 3'd0;  e.zero = 1'b1;
      qf.push_back(e);  qn.push_back(e);  q5.push_back(e);
      @(negedge clk);
      if_5.in_valid = 1'b0;

      // Hand-computed directed values.
      drive(1'b1, 8'hFF, 7, 1'b0);
      drive(1'b1, 8'h03, 1, 1'b0);
      drive(1'b1, 8'h01, 0, 1'b0);
      drive(1'b1, 8'h00, 0, 1'b1);

      // One-hot walk, back-to-back.
      for (int i = 0; i < 8; i++) begin
         v8 = 8'h01 << i;
         drive(1'b1, v8, i, 1'b0);
      end

      // Leading one at i, unknown bits below it.
      for (int i = 0; i < 8; i++) begin
         v8 = 8'h00;
         v8[i] = 1'b1;
         for (int j = 0; j < i; j++) v8[j] = 1'bx;
         drive(1'b1, v8, i, 1'b0);
      end

      // Valid gating: result held across an idle cycle.
      drive(1'b1, 8'h80, 7, 1'b0);
      drive(1'b0, 8'h01, 0, 1'b0);
      drive(1'b1, 8'h20, 5, 1'b0);

      // Exhaustive sweep.
      for (int k = 0; k < 256; k++) begin
         v8 = 8'(k);
         drive(1'b1, v8, ref_msb8(v8), (k == 0) ? 1'b1 : 1'b0);
      end

      // Asynchronous reset in the middle of a stream.
      drive(1'b1, 8'h80, 7, 1'b0);
      @(negedge clk);
      if_f.in_valid = 1'b1;  if_f.Sum_mag = 8'h40;
      if_n.in_valid = 1'b1;  if_n.Sum_mag = 8'h40;
      #1 rst = 1'b1;
      #1;
      chk("async_rst_fpga_out_valid", 8'(if_f.out_valid), 8'h00);
      chk("async_rst_fpga_msb_pos",   8'(if_f.msb_pos),   8'h00);
      chk("async_rst_fpga_zero",      8'(if_f.zero),      8'h01);
      chk("async_rst_naive_msb_pos",  8'(if_n.msb_pos),   8'h00);
      @(posedge clk);
      #1;
      chk("rst_hold_fpga_out_valid", 8'(if_f.out_valid), 8'h00);
      chk("rst_hold_naive_msb_pos",  8'(if_n.msb_pos),   8'h00);
      @(negedge clk);
      rst = 1'b0;
      if_f.Sum_mag = 8'h10;  if_n.Sum_mag = 8'h10;
      hold_pos = 3'd4;  hold_zero = 1'b0;
      e.ov = 1'b1;  e.pos = 3'd4;  e.zero = 1'b0;
      qf.push_back(e);  qn.push_back(e);
      drive(1'b0, 8'h00, 0, 1'b0);

      // Non-power-of-two width.
      drive5(5'b10000, 4, 1'b0);
      drive5(5'b00110, 2, 1'b0);
      drive5(5'b00000, 0, 1'b1);
      drive5(5'b11111, 4, 1'b0);
      drive5(5'b00001, 0, 1'b0);
      @(negedge clk);
      if_5.in_valid = 1'b0;

      // Every queued expectation must have been consumed.
      repeat (4) @(negedge clk);
      chk("drain_fpga",  8'(qf.size()), 8'h00);
      chk("drain_naive", 8'(qn.size()), 8'h00);
      chk("drain_w5",    8'(q5.size()), 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/leading_1_in_mantissa.md
Name: leading_1_in_mantissa

Overview:
- Priority encoder returning the bit index of the most-significant '1' in an unsigned mantissa magnitude.
- Used in the floating-point adder normalisation path to compute the left-shift amount after addition/subtraction.
- One registered output stage: input sampled on a clock edge, result valid the following cycle.
- Two selectable encoder architectures with identical function.

Parameters:
- WIDTH, default 8: mantissa width in bits; legal range 2..64, non-power-of-two allowed.
- WIDTH_LOG, localparam = $clog2(WIDTH): width of the position output.
- IMPLEMENTATION, default "FPGA": "NAIVE" = linear priority chain; "FPGA" = balanced binary-tree encoder. Any other string causes an elaboration-time $fatal.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: asynchronous, active-high reset.
- in_valid, input, 1: Sum_mag is valid this cycle.
- Sum_mag, input, WIDTH: magnitude to encode.
- out_valid, output, 1: msb_pos and zero are valid.
- msb_pos, output, WIDTH_LOG: index of the highest set bit of the sampled Sum_mag.
- zero, output, 1: sampled Sum_mag was all zeros.

Behaviour:
- Combinational core:
  - pos = largest i with Sum_mag[i]==1.
  - pos = 0 when Sum_mag == 0; also 0 when only bit 0 is set.
  - zero = ~|Sum_mag.
- X-tolerance:
  - Bits below the leading 1 must not influence pos.
  - With Sum_mag[i]=1, bits above i = 0 and bits below i = X, pos must be exactly i with no X.
  - Neither implementation may use constructs that propagate X from lower-priority bits.
- FPGA tree:
  - Pad Sum_mag with zeros to 2**WIDTH_LOG.
  - Each level merges pairs (valid_hi, pos_hi) / (valid_lo, pos_lo) into valid = v_hi|v_lo, pos = v_hi ? {1,pos_hi} : {0,pos_lo}.
  - The final valid is ~zero.
- Register stage:
  - On posedge clk with in_valid=1: msb_pos <= pos, zero <= zero_comb, out_valid <= 1.
  - On posedge clk with in_valid=0: out_valid <= 0; msb_pos and zero hold their last values.
- Latency is exactly 1 cycle; throughput is 1 result per cycle; back-to-back inputs are allowed.
- Reset:
  - rst=1 asynchronously forces out_valid=0, msb_pos=0, zero=1, independent of clk.
  - Reset asserted mid-stream discards any in-flight result.
  - The first capture occurs on the first rising edge after rst deasserts.
- No backpressure.
- Both IMPLEMENTATION values must be cycle- and bit-identical for all defined inputs.

Decomposition:
- Package leading_1_pkg:
  - function msb_pos_ref(logic [63:0] v, int width): behavioural reference encoder for benches and the NAIVE path.
  - Enum/string constants "NAIVE" and "FPGA".
- One sub-module, leading_1_tree_node: parameterised pairwise merge node (width of pos) used recursively/generated for the FPGA tree.
- The register stage lives in the top module.

Test Plan:
- Reset/idle: assert rst with Sum_mag=8'h00, in_valid=1 -> out_valid=0, msb_pos=0, zero=1 during reset. After release, one cycle later -> msb_pos=0, zero=1, out_valid=1.
- One-hot: drive Sum_mag=1<<i for i=0..7 on consecutive cycles -> msb_pos=i one cycle later; zero=0 for all i, including i=0 (msb_pos=0).
- Priority with X: Sum_mag[i]=1, upper bits 0, lower bits X, e.g. 8'b0001_xxxx -> msb_pos=4, no X on msb_pos; repeat for i=0..7.
- Exhaustive: all 256 values back-to-back, WIDTH=8, both IMPLEMENTATION values -> msb_pos matches msb_pos_ref each cycle with 1-cycle lag. Examples: 8'hFF->7, 8'h03->1, 8'h01->0.
- Valid gating: in_valid toggling 1,0,1 with Sum_mag 8'h80, 8'h01, 8'h20 -> out_valid 1,0,1; msb_pos 7, 7 (held), 5.
- Non-power-of-two WIDTH=5: Sum_mag=5'b10000 -> 4; 5'b00110 -> 2; 5'b0 -> 0 with zero=1.
